// File: rtl/syb_mapping_pipe.sv
// -----------------------------------------------------------------------------
// syb_mapping_pipe
//
// Buffered, multi-lane 3B2T symbol mapper for the 100BASE-T1 PCS transmit
// path. Each lane's 3-bit scrambled word Sdn, together with its Sxn bit, is
// queued in a small FIFO and turned into a ternary pair (TA, TB) when the
// symbol-rate strobe sym_en fires.
//
// Ternary encoding on TAn/TBn (2 bits per lane): -1 = 01, 0 = 00, +1 = 11.
//
// Handshake: a word is accepted on every rising clk edge where
// sdn_vld & sdn_rdy. sdn_rdy depends on registered state only (FIFO count and
// the mode latched on the last strobe), so it never combinationally follows
// sdn_vld, sym_en or tx_mode.
//
// Ports
//   clk, rst_n   : PCS clock, asynchronous active-low reset
//   sym_en       : symbol strobe, one output symbol per strobe
//   tx_mode      : 0 SEND_Z, 1 SEND_I, 2 SEND_N, 3 reserved
//   tx_enable    : MII transmit enable (selects data mapping in SEND_N)
//   sdn_vld/rdy  : input word handshake
//   sdn, sxn     : per-lane Sdn (3 bits) and Sxn (1 bit)
//   udf_clr      : clears the sticky underflow indicators
//   TAn, TBn     : per-lane ternary outputs, held between strobes
//   tn_vld       : pulses the cycle after every sym_en
//   udf_pulse    : pulses the cycle after a strobe that found the FIFO empty
//   udf_flag     : sticky underflow indicator
//   udf_cnt      : saturating underflow counter, only when the macro
//                  SYB_MAP_UDF_CNT_EN is defined
// -----------------------------------------------------------------------------
module syb_mapping_pipe #(
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sym_en,
    input  logic [1:0]           tx_mode,
    input  logic                 tx_enable,
    input  logic                 sdn_vld,
    output logic                 sdn_rdy,
    input  logic [3*LANES-1:0]   sdn,
    input  logic [LANES-1:0]     sxn,
    input  logic                 udf_clr,
    output logic [2*LANES-1:0]   TAn,
    output logic [2*LANES-1:0]   TBn,
    output logic                 tn_vld,
    output logic                 udf_pulse,
    output logic                 udf_flag
`ifdef SYB_MAP_UDF_CNT_EN
    ,
    output logic [15:0]          udf_cnt
`endif
);

    localparam logic [1:0] SEND_Z = 2'd0;
    localparam logic [1:0] SEND_I = 2'd1;
    localparam logic [1:0] SEND_N = 2'd2;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = 4 * LANES;   // per lane: {sxn, sdn[2:0]}

    // Ternary codes
    localparam logic [1:0] T_M = 2'b01;
    localparam logic [1:0] T_Z = 2'b00;
    localparam logic [1:0] T_P = 2'b11;

    logic [1:0]    mode_q;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          empty;
    logic          data_mode;
    logic          flush;
    logic          pop;
    logic          push;
    logic          underflow;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    logic [2*LANES-1:0] ta_nxt;
    logic [2*LANES-1:0] tb_nxt;
    logic [3:0]    sym;

    // Returns {TA, TB}. Only called for SEND_I / SEND_N strobes.
    function automatic logic [3:0] map_sym(input logic [1:0] mode,
                                           input logic       en,
                                           input logic       x,
                                           input logic [2:0] s);
        logic [3:0] r;
        r = {T_Z, T_Z};
        if (mode == SEND_N && en) begin
            // Data mapping; Sxn has no effect here.
            case (s)
                3'b000: r = {T_M, T_M};
                3'b001: r = {T_M, T_Z};
                3'b010: r = {T_M, T_P};
                3'b011: r = {T_Z, T_M};
                3'b100: r = {T_Z, T_P};
                3'b101: r = {T_P, T_M};
                3'b110: r = {T_P, T_Z};
                default: r = {T_P, T_P};
            endcase
        end else if (mode == SEND_N && x) begin
            case (s)
                3'b000: r = {T_M, T_Z};
                3'b001: r = {T_P, T_P};
                3'b010: r = {T_M, T_P};
                3'b011: r = {T_P, T_P};
                3'b100: r = {T_P, T_Z};
                3'b101: r = {T_M, T_M};
                3'b110: r = {T_P, T_M};
                default: r = {T_M, T_M};
            endcase
        end else begin
            // Idle mapping: SEND_I, or SEND_N idle with Sxn = 0.
            case (s)
                3'b000: r = {T_M, T_Z};
                3'b001: r = {T_Z, T_P};
                3'b010: r = {T_M, T_P};
                3'b011: r = {T_Z, T_P};
                3'b100: r = {T_P, T_Z};
                3'b101: r = {T_Z, T_M};
                3'b110: r = {T_P, T_M};
                default: r = {T_Z, T_M};
            endcase
        end
        return r;
    endfunction

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign sdn_rdy   = !full && (mode_q != SEND_Z);

    // The strobe acts on the live tx_mode, not on mode_q.
    assign data_mode = (tx_mode == SEND_I) || (tx_mode == SEND_N);
    assign flush     = sym_en && (tx_mode == SEND_Z);
    assign pop       = sym_en && data_mode && !empty;
    assign underflow = sym_en && data_mode && empty;
    // A word offered during a SEND_Z strobe is dropped with the flush.
    assign push      = sdn_vld && sdn_rdy && !flush;

    assign rd_word   = mem[rd_ptr];

    always_comb begin
        wr_word = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_word[4*l +: 4] = {sxn[l], sdn[3*l +: 3]};
        end
    end

    always_comb begin
        ta_nxt = '0;
        tb_nxt = '0;
        sym    = '0;
        if (pop) begin
            for (int l = 0; l < LANES; l++) begin
                sym = map_sym(tx_mode, tx_enable, rd_word[4*l+3], rd_word[4*l +: 3]);
                ta_nxt[2*l +: 2] = sym[3:2];
                tb_nxt[2*l +: 2] = sym[1:0];
            end
        end
    end

    // FIFO storage has no reset; its contents are meaningless once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mode_q <= SEND_Z;
        end else begin
            if (sym_en) begin
                mode_q <= tx_mode;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TAn       <= '0;
            TBn       <= '0;
            tn_vld    <= 1'b0;
            udf_pulse <= 1'b0;
            udf_flag  <= 1'b0;
        end else begin
            tn_vld    <= sym_en;
            udf_pulse <= underflow;
            if (sym_en) begin
                // Zeros for SEND_Z, reserved mode and underflow.
                TAn <= ta_nxt;
                TBn <= tb_nxt;
            end
            // A fresh underflow beats a simultaneous clear.
            if (underflow) begin
                udf_flag <= 1'b1;
            end else if (udf_clr) begin
                udf_flag <= 1'b0;
            end
        end
    end

`ifdef SYB_MAP_UDF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            udf_cnt <= '0;
        end else if (underflow) begin
            if (udf_clr) begin
                udf_cnt <= 16'd1;
            end else if (udf_cnt != 16'hFFFF) begin
                udf_cnt <= udf_cnt + 16'd1;
            end
        end else if (udf_clr) begin
            udf_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_syb_mapping_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for syb_mapping_pipe (LANES = 2, FIFO_DEPTH = 4).
// A queue-based model predicts every output; a negedge process compares it
// with the DUT each cycle, and the directed sequence adds literal checks.
// -----------------------------------------------------------------------------
module tb_syb_mapping_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                sym_en = 1'b0;
  logic [1:0]          tx_mode = 2'd0;
  logic                tx_enable = 1'b0;
  logic                sdn_vld = 1'b0;
  logic                sdn_rdy;
  logic [3*LANES-1:0]  sdn = '0;
  logic [LANES-1:0]    sxn = '0;
  logic                udf_clr = 1'b0;
  logic [2*LANES-1:0]  TAn;
  logic [2*LANES-1:0]  TBn;
  logic                tn_vld;
  logic                udf_pulse;
  logic                udf_flag;
`ifdef SYB_MAP_UDF_CNT_EN
  logic [15:0]         udf_cnt;
`endif

  syb_mapping_pipe #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sym_en(sym_en),
    .tx_mode(tx_mode),
    .tx_enable(tx_enable),
    .sdn_vld(sdn_vld),
    .sdn_rdy(sdn_rdy),
    .sdn(sdn),
    .sxn(sxn),
    .udf_clr(udf_clr),
    .TAn(TAn),
    .TBn(TBn),
    .tn_vld(tn_vld),
    .udf_pulse(udf_pulse),
    .udf_flag(udf_flag)
`ifdef SYB_MAP_UDF_CNT_EN
    ,
    .udf_cnt(udf_cnt)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ternary values of the three mapping tables, indexed by Sdn.
  int ta_a[8] = '{-1, 0, -1, 0, 1, 0, 1, 0};
  int tb_a[8] = '{ 0, 1,  1, 1, 0, -1, -1, -1};
  int ta_b[8] = '{-1, 1, -1, 1, 1, -1, 1, -1};
  int tb_b[8] = '{ 0, 1,  1, 1, 0, -1, -1, -1};
  int ta_c[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int tb_c[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  function automatic logic [1:0] enc(input int v);
    if (v < 0) return 2'b01;
    if (v > 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [3:0] model_sym(input logic [1:0] mode, input bit en,
                                           input bit x, input int s);
    int ta, tb;
    if (mode == 2'd2 && en) begin
      ta = ta_c[s]; tb = tb_c[s];
    end else if (mode == 2'd2 && x) begin
      ta = ta_b[s]; tb = tb_b[s];
    end else begin
      ta = ta_a[s]; tb = tb_a[s];
    end
    return {enc(ta), enc(tb)};
  endfunction

  // Queue entry: {sxn1, sdn1, sxn0, sdn0}
  logic [7:0]  exp_q[$];
  logic [1:0]  m_mode = 2'd0;
  logic [3:0]  e_ta = '0;
  logic [3:0]  e_tb = '0;
  logic        e_vld = 1'b0;
  logic        e_udf = 1'b0;
  logic        e_flag = 1'b0;
  int          e_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 2'd0;
      e_ta = '0; e_tb = '0; e_vld = 1'b0; e_udf = 1'b0; e_flag = 1'b0; e_cnt = 0;
    end else begin : upd
      bit acc;
      bit und;
      logic [7:0] w;
      logic [3:0] r0, r1;
      acc = sdn_vld && (exp_q.size() < DEPTH) && (m_mode != 2'd0);
      und = 1'b0;
      e_vld = sym_en;
      if (sym_en) begin
        e_ta = '0;
        e_tb = '0;
        if (tx_mode == 2'd0) begin
          exp_q.delete();
          acc = 1'b0;
        end else if (tx_mode != 2'd3) begin
          if (exp_q.size() == 0) begin
            und = 1'b1;
          end else begin
            w = exp_q.pop_front();
            r0 = model_sym(tx_mode, tx_enable, w[3], int'(w[2:0]));
            r1 = model_sym(tx_mode, tx_enable, w[7], int'(w[6:4]));
            e_ta = {r1[3:2], r0[3:2]};
            e_tb = {r1[1:0], r0[1:0]};
          end
        end
        m_mode = tx_mode;
      end
      if (acc) exp_q.push_back({sxn[1], sdn[5:3], sxn[0], sdn[2:0]});
      e_udf = und;
      if (und) e_flag = 1'b1;
      else if (udf_clr) e_flag = 1'b0;
      if (und) e_cnt = udf_clr ? 1 : ((e_cnt == 65535) ? e_cnt : e_cnt + 1);
      else if (udf_clr) e_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cyc_tan", TAn, e_ta);
    chk("cyc_tbn", TBn, e_tb);
    chk("cyc_tn_vld", tn_vld, e_vld);
    chk("cyc_udf_pulse", udf_pulse, e_udf);
    chk("cyc_udf_flag", udf_flag, e_flag);
    chk("cyc_sdn_rdy", sdn_rdy, (exp_q.size() < DEPTH) && (m_mode != 2'd0));
`ifdef SYB_MAP_UDF_CNT_EN
    chk("cyc_udf_cnt", udf_cnt, e_cnt);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] s0, input logic x0,
                      input logic [2:0] s1, input logic x1);
    sdn = {s1, s0};
    sxn = {x1, x0};
    sdn_vld = 1'b1;
    tick();
    sdn_vld = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] mode, input logic en);
    tx_mode = mode;
    tx_enable = en;
    sym_en = 1'b1;
    tick();
    sym_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_tan", TAn, 0);
    chk("rst_tbn", TBn, 0);
    chk("rst_tn_vld", tn_vld, 0);
    chk("rst_udf_pulse", udf_pulse, 0);
    chk("rst_udf_flag", udf_flag, 0);
    chk("rst_sdn_rdy", sdn_rdy, 0);

    // Reserved-mode strobe opens the FIFO without an underflow
    strobe(2'd3, 1'b0);
    chk("prime_rdy", sdn_rdy, 1);
    chk("prime_vld", tn_vld, 1);
    chk("prime_no_udf", udf_pulse, 0);

    // SEND_I: 010 -> (-1,+1); lane 1 110 -> (+1,-1)
    push(3'b010, 1'b0, 3'b110, 1'b1);
    strobe(2'd1, 1'b0);
    chk("t1_ta0", TAn[1:0], 2'b01);
    chk("t1_tb0", TBn[1:0], 2'b11);
    chk("t1_ta1", TAn[3:2], 2'b11);
    chk("t1_tb1", TBn[3:2], 2'b01);
    chk("t1_vld", tn_vld, 1);
    tick();
    chk("t1_vld_pulse", tn_vld, 0);
    chk("t1_hold", TAn[1:0], 2'b01);

    // SEND_N data mapping, sxn ignored
    push(3'b000, 1'b1, 3'b011, 1'b0);
    push(3'b111, 1'b1, 3'b001, 1'b1);
    push(3'b101, 1'b0, 3'b100, 1'b0);
    strobe(2'd2, 1'b1);
    chk("t2a_ta", TAn[1:0], 2'b01);
    chk("t2a_tb", TBn[1:0], 2'b01);
    strobe(2'd2, 1'b1);
    chk("t2b_ta", TAn[1:0], 2'b11);
    chk("t2b_tb", TBn[1:0], 2'b11);
    strobe(2'd2, 1'b1);
    chk("t2c_ta", TAn[1:0], 2'b11);
    chk("t2c_tb", TBn[1:0], 2'b01);

    // SEND_N idle with sxn = 1
    push(3'b001, 1'b1, 3'b010, 1'b0);
    push(3'b101, 1'b1, 3'b000, 1'b1);
    strobe(2'd2, 1'b0);
    chk("t3a_ta", TAn[1:0], 2'b11);
    chk("t3a_tb", TBn[1:0], 2'b11);
    strobe(2'd2, 1'b0);
    chk("t3b_ta", TAn[1:0], 2'b01);
    chk("t3b_tb", TBn[1:0], 2'b01);

    // Fill to full, fifth word refused
    push(3'b100, 1'b0, 3'b011, 1'b1);
    push(3'b001, 1'b0, 3'b111, 1'b0);
    push(3'b110, 1'b1, 3'b010, 1'b1);
    chk("fill3_rdy", sdn_rdy, 1);
    push(3'b011, 1'b0, 3'b101, 1'b1);
    chk("full_rdy", sdn_rdy, 0);
    push(3'b111, 1'b1, 3'b111, 1'b1);
    chk("full_rdy_hold", sdn_rdy, 0);
    strobe(2'd1, 1'b0);
    chk("drain1_ta", TAn[1:0], 2'b11);
    chk("drain1_tb", TBn[1:0], 2'b00);
    chk("drain1_rdy", sdn_rdy, 1);
    strobe(2'd1, 1'b0);
    strobe(2'd1, 1'b0);
    strobe(2'd1, 1'b0);
    chk("drain4_ta", TAn[1:0], 2'b00);
    chk("drain4_tb", TBn[1:0], 2'b11);
    strobe(2'd1, 1'b0);
    chk("udf_ta", TAn, 0);
    chk("udf_tb", TBn, 0);
    chk("udf_vld", tn_vld, 1);
    chk("udf_pulse", udf_pulse, 1);
    chk("udf_flag", udf_flag, 1);
`ifdef SYB_MAP_UDF_CNT_EN
    chk("udf_cnt", udf_cnt, 1);
`endif
    tick();
    chk("udf_pulse_end", udf_pulse, 0);
    chk("udf_flag_sticky", udf_flag, 1);
    udf_clr = 1'b1;
    tick();
    udf_clr = 1'b0;
    chk("udf_clr", udf_flag, 0);
    // Clear coinciding with a new underflow: set wins
    udf_clr = 1'b1;
    strobe(2'd1, 1'b0);
    udf_clr = 1'b0;
    chk("clr_vs_set_flag", udf_flag, 1);
`ifdef SYB_MAP_UDF_CNT_EN
    chk("clr_vs_set_cnt", udf_cnt, 1);
`endif

    // SEND_Z flush with 3 words buffered and a push in the same cycle
    push(3'b010, 1'b0, 3'b010, 1'b0);
    push(3'b100, 1'b0, 3'b100, 1'b0);
    push(3'b110, 1'b0, 3'b110, 1'b0);
    sdn = 6'b111_111;
    sdn_vld = 1'b1;
    strobe(2'd0, 1'b0);
    sdn_vld = 1'b0;
    chk("flush_ta", TAn, 0);
    chk("flush_vld", tn_vld, 1);
    chk("flush_rdy", sdn_rdy, 0);
    tick();
    chk("flush_rdy_hold", sdn_rdy, 0);
    strobe(2'd3, 1'b0);
    chk("reprime_rdy", sdn_rdy, 1);
    strobe(2'd1, 1'b0);
    chk("flush_empty_udf", udf_pulse, 1);

    // Reserved mode keeps buffered words
    push(3'b111, 1'b0, 3'b000, 1'b0);
    strobe(2'd3, 1'b0);
    chk("rsv_ta", TAn, 0);
    chk("rsv_no_udf", udf_pulse, 0);
    strobe(2'd1, 1'b0);
    chk("rsv_keep_ta", TAn[1:0], 2'b00);
    chk("rsv_keep_tb", TBn[1:0], 2'b01);
    chk("rsv_keep_udf", udf_pulse, 0);

    // Asynchronous reset mid-stream with 2 words still buffered
    push(3'b010, 1'b0, 3'b001, 1'b0);
    push(3'b011, 1'b0, 3'b011, 1'b0);
    push(3'b100, 1'b0, 3'b101, 1'b0);
    strobe(2'd1, 1'b0);
    chk("pre_rst_ta", TAn[1:0], 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ta", TAn, 0);
    chk("arst_tb", TBn, 0);
    chk("arst_vld", tn_vld, 0);
    chk("arst_flag", udf_flag, 0);
    chk("arst_rdy", sdn_rdy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    strobe(2'd3, 1'b0);
    strobe(2'd1, 1'b0);
    chk("post_rst_udf", udf_pulse, 1);
    chk("post_rst_ta", TAn, 0);

    // Back-to-back strobes with a push every cycle
    for (int i = 0; i < 24; i++) begin
      sdn = 6'($urandom_range(0, 63));
      sxn = 2'($urandom_range(0, 3));
      sdn_vld = 1'b1;
      tx_mode = (i < 12) ? 2'd2 : 2'd1;
      tx_enable = 1'($urandom_range(0, 1));
      sym_en = 1'b1;
      tick();
    end
    sdn_vld = 1'b0;
    sym_en = 1'b0;
    // Irregular strobes and pushes
    for (int i = 0; i < 30; i++) begin
      sdn = 6'($urandom_range(0, 63));
      sxn = 2'($urandom_range(0, 3));
      sdn_vld = 1'($urandom_range(0, 1));
      tx_mode = 2'($urandom_range(1, 2));
      tx_enable = 1'($urandom_range(0, 1));
      sym_en = ($urandom_range(0, 2) == 0);
      udf_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    sdn_vld = 1'b0;
    sym_en = 1'b0;
    udf_clr = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
